// File: rtl/line_clear_engine_if.sv
// Bus between the game FSM (master) and the line-clear engine (slave).
// Build option: LCE_SCORE_EN adds the running score signal to both modports.
interface line_clear_engine_if #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 4,
  parameter int unsigned SCORE_W = 16
);
  localparam int unsigned LW = $clog2(ROWS + 1);

  logic                   start;
  logic [ROWS*COLS-1:0]   board_in;
  logic [ROWS*COLS-1:0]   board_out;
  logic [LW-1:0]          lines;
  logic                   busy;
  logic                   done;
  logic                   error;

  // Reject degenerate geometries at elaboration time.
  if (ROWS < 2 || COLS < 2 || SCORE_W < 1) begin : g_param_check
    $error("line_clear_engine_if: ROWS and COLS must be >= 2, SCORE_W >= 1");
  end

`ifdef LCE_SCORE_EN
  logic [SCORE_W-1:0]     score;

  modport master (
    output start, board_in,
    input  board_out, lines, busy, done, error, score
  );

  modport slave (
    input  start, board_in,
    output board_out, lines, busy, done, error, score
  );
`else
  modport master (
    output start, board_in,
    input  board_out, lines, busy, done, error
  );

  modport slave (
    input  start, board_in,
    output board_out, lines, busy, done, error
  );
`endif

endinterface

// File: rtl/line_clear_engine.sv
// Line-clear / compaction engine: scans a captured board bottom to top, drops full rows,
// packs the survivors downwards, zero-fills the top and reports the number of rows removed.
// Build option: LCE_SCORE_EN enables a saturating score accumulator (score += lines^2).
module line_clear_engine #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned COLS    = 4,
  parameter int unsigned SCORE_W = 16
) (
  input logic                clka,
  input logic                restart,
  line_clear_engine_if.slave bus
);

  localparam int unsigned LW = $clog2(ROWS + 1);
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW = ROWS * COLS;

  if (ROWS < 2 || COLS < 2 || SCORE_W < 1) begin : g_param_check
    $error("line_clear_engine: ROWS and COLS must be >= 2, SCORE_W >= 1");
  end

  typedef enum logic [1:0] {StIdle, StScan, StFill, StDone} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   out_q, out_d;
  logic [BW-1:0]   board_out_q, board_out_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [RW-1:0]   wr_q, wr_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   lines_q, lines_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic [COLS-1:0] row_cur;

  // Row currently under the read pointer.
  assign row_cur = work_q[rd_q*COLS +: COLS];

  // Next-state and datapath decode for the scan/fill/done sequence.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    out_d       = out_q;
    board_out_d = board_out_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    done_d      = 1'b0;
    // A request while a pass (including its done cycle) is active is a protocol error.
    error_d     = error_q | (bus.start & busy_q);

    unique case (state_q)
      StIdle: begin
        if (bus.start && !busy_q) begin
          work_d  = bus.board_in;
          rd_d    = RW'(ROWS - 1);
          wr_d    = RW'(ROWS - 1);
          cnt_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (&row_cur) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          out_d[wr_q*COLS +: COLS] = row_cur;
          // Saturate so an all-kept board leaves wr at row 0 instead of wrapping.
          if (wr_q != '0) wr_d = wr_q - 1'b1;
        end
        if (rd_q == '0) begin
          state_d = StFill;
        end else begin
          rd_d = rd_q - 1'b1;
        end
      end
      StFill: begin
        // With nothing removed every row was rewritten and wr is parked on a live row.
        if (cnt_q != '0) begin
          for (int unsigned r = 0; r < ROWS; r++) begin
            if (r <= 32'(wr_q)) out_d[r*COLS +: COLS] = '0;
          end
        end
        state_d = StFill == state_q ? StDone : state_q;
      end
      StDone: begin
        board_out_d = out_q;
        lines_d     = cnt_q;
        done_d      = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Busy also covers the cycle in which the done pulse is visible.
    busy_d = (state_d != StIdle) || (state_q == StDone);
  end

  // State and datapath registers; restart wins over everything.
  always_ff @(posedge clka) begin
    if (restart) begin
      state_q     <= StIdle;
      work_q      <= '0;
      out_q       <= '0;
      board_out_q <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      lines_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      out_q       <= out_d;
      board_out_q <= board_out_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.board_out = board_out_q;
  assign bus.lines     = lines_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

`ifdef LCE_SCORE_EN
  // Wide enough that score + cnt^2 can never overflow before the saturation compare.
  localparam int unsigned SUM_W = SCORE_W + 2 * LW + 1;

  logic [SCORE_W-1:0] score_q, score_d;
  logic [SUM_W-1:0]   score_sum;

  // Saturating accumulate of lines^2, applied as the pass result is published.
  always_comb begin
    score_sum = SUM_W'(score_q) + SUM_W'(cnt_q) * SUM_W'(cnt_q);
    score_d   = score_q;
    if (state_q == StDone) begin
      score_d = (score_sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
    end
  end

  // Score register; cleared only by restart.
  always_ff @(posedge clka) begin
    if (restart) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign bus.score = score_q;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// Randomized self-checking bench for line_clear_engine against a row-list reference model.
module tb_line_clear_engine;

  localparam int unsigned ROWS    = 8;
  localparam int unsigned COLS    = 4;
  localparam int unsigned SCORE_W = 8;
  localparam int unsigned BW      = ROWS * COLS;

  logic clka = 1'b0;
  logic restart;

  line_clear_engine_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(SCORE_W)) bus ();

  line_clear_engine #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .SCORE_W (SCORE_W)
  ) dut (
    .clka    (clka),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clka = ~clka;

  int unsigned     n_pass  = 0;
  int unsigned     n_total = 0;
  longint unsigned score_m = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: keep non-full rows in bottom-to-top order, stack them on the floor, zero the rest.
  function automatic void model(input logic [BW-1:0] b, output logic [BW-1:0] o,
                                output int unsigned l);
    logic [COLS-1:0] kept[$];
    logic [COLS-1:0] row;
    logic [COLS-1:0] full;
    full = '1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[r*COLS +: COLS];
      if (row != full) kept.push_back(row);
    end
    l = ROWS - kept.size();
    o = '0;
    foreach (kept[i]) o[(ROWS - 1 - i)*COLS +: COLS] = kept[i];
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_board_out"}, 64'(bus.board_out), 64'd0);
    check_eq({tag, "_lines"}, 64'(bus.lines), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_error"}, 64'(bus.error), 64'd0);
`ifdef LCE_SCORE_EN
    check_eq({tag, "_score"}, 64'(bus.score), 64'd0);
`endif
  endtask

  // One pass; optionally re-pulses start 'second_at' cycles after acceptance.
  task automatic run_pass(input string tag, input logic [BW-1:0] b, input int second_at,
                          input logic exp_err);
    logic [BW-1:0] exp_o;
    int unsigned   exp_l;
    int            n;
    bit            seen;
    longint unsigned max_s;
    model(b, exp_o, exp_l);
    bus.board_in = b;
    bus.start    = 1'b1;
    @(posedge clka);
    #1;
    bus.start    = 1'b0;
    bus.board_in = ~b;  // must not affect the pass
    check_eq({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < int'(ROWS) + 6) begin
      if (n + 1 == second_at) bus.start = 1'b1;
      @(posedge clka);
      #1;
      bus.start = 1'b0;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(ROWS + 2));
    check_eq({tag, "_board_out"}, 64'(bus.board_out), 64'(exp_o));
    check_eq({tag, "_lines"}, 64'(bus.lines), 64'(exp_l));
    check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    check_eq({tag, "_error"}, 64'(bus.error), 64'(exp_err));
    max_s   = (64'd1 << SCORE_W) - 1;
    score_m = (score_m + exp_l * exp_l > max_s) ? max_s : score_m + exp_l * exp_l;
`ifdef LCE_SCORE_EN
    check_eq({tag, "_score"}, 64'(bus.score), score_m);
`endif
    @(posedge clka);
    #1;
    check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_hold"}, 64'(bus.board_out), 64'(exp_o));
  endtask

  initial begin
    logic [BW-1:0]   b;
    logic [COLS-1:0] row;

    // T1: reset
    restart      = 1'b1;
    bus.start    = 1'b0;
    bus.board_in = '0;
    repeat (2) @(posedge clka);
    #1;
    restart = 1'b0;
    score_m = 0;
    check_reset_state("t1");

    // T2..T5: directed boards
    run_pass("t2", 32'hEEEEEE00, -1, 1'b0);
    run_pass("t3", 32'hF1000000, -1, 1'b0);
    run_pass("t4", 32'hF3F20000, -1, 1'b0);
    run_pass("t5", 32'hFFFFFFFF, -1, 1'b0);

    // Random boards with roughly one row in three full
    for (int k = 0; k < 20; k++) begin
      b = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        row = ($urandom_range(0, 2) == 0) ? '1 : COLS'($urandom);
        b[r*COLS +: COLS] = row;
      end
      run_pass($sformatf("rnd%0d", k), b, -1, 1'b0);
    end

    // T6: second start mid-pass flags error, pass still completes
    run_pass("t6", 32'h0F0FF0F0, 3, 1'b1);

    // Restart in the middle of SCAN
    bus.board_in = 32'hFFFF1234;
    bus.start    = 1'b1;
    @(posedge clka);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clka);
    #1;
    restart = 1'b1;
    @(posedge clka);
    #1;
    restart = 1'b0;
    score_m = 0;
    check_reset_state("t6_restart");
    repeat (ROWS + 4) @(posedge clka);
    #1;
    check_eq("t6_quiet_done", 64'(bus.done), 64'd0);
    run_pass("t6_clean", 32'hFF12F3FF, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
